// File: rtl/clock_ratio_meter_if.sv
// Bus between a measurement controller and clock_ratio_meter: control/measured
// signal in, period/high-time results and status flags out.
interface clock_ratio_meter_if #(
  parameter int CNT_W = 16
);
  logic             en;
  logic             sig_in;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             valid;
  logic             locked;
  logic             timeout;

  modport master (
    output en, sig_in,
    input  period, high_time, valid, locked, timeout
  );

  modport slave (
    input  en, sig_in,
    output period, high_time, valid, locked, timeout
  );
endinterface

// File: rtl/clock_ratio_meter.sv
// Measures period and high time of a slow, asynchronous square wave in
// clk_in cycles, publishing each result on a rising edge of the signal.
module clock_ratio_meter #(
  parameter int CNT_W = 16
) (
  input logic               clk_in,
  input logic               nrst,
  clock_ratio_meter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_r, state_nxt_s;
  logic             s1_r, s2_r, s3_r;
  logic             rise_s, fall_s;
  logic             arm_s, publish_s, sat_s;
  logic [CNT_W-1:0] cnt_r, hi_hold_r, prev_r;
  logic [CNT_W-1:0] period_r, high_time_r;
  logic             valid_r, locked_r, timeout_r;

  assign rise_s = s2_r & ~s3_r;
  assign fall_s = ~s2_r & s3_r;

  // Two-flop synchronizer plus one delay flop for edge detection
  always_ff @(posedge clk_in or negedge nrst) begin
    if (!nrst) begin
      s1_r <= 1'b0;
      s2_r <= 1'b0;
      s3_r <= 1'b0;
    end else begin
      s1_r <= bus.sig_in;
      s2_r <= s1_r;
      s3_r <= s2_r;
    end
  end

  // State register
  always_ff @(posedge clk_in or negedge nrst) begin
    if (!nrst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode; en dominates a rise, a rise dominates saturation
  always_comb begin
    state_nxt_s = state_r;
    arm_s       = 1'b0;
    publish_s   = 1'b0;
    sat_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.en && rise_s) begin
          state_nxt_s = ARMED;
          arm_s       = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ARMED, RUN: begin
        if (!bus.en) begin
          state_nxt_s = IDLE;
        end else if (rise_s) begin
          state_nxt_s = RUN;
          publish_s   = 1'b1;
        end else if (cnt_r == CNT_MAX) begin
          state_nxt_s = IDLE;
          sat_s       = 1'b1;
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Counter, high-time capture and published results
  always_ff @(posedge clk_in or negedge nrst) begin
    if (!nrst) begin
      cnt_r       <= CNT_ZERO;
      hi_hold_r   <= CNT_ZERO;
      prev_r      <= CNT_ZERO;
      period_r    <= CNT_ZERO;
      high_time_r <= CNT_ZERO;
      valid_r     <= 1'b0;
      locked_r    <= 1'b0;
      timeout_r   <= 1'b0;
    end else begin
      valid_r <= publish_s;
      if (state_r == IDLE) begin
        if (arm_s) begin
          cnt_r     <= CNT_ONE;
          hi_hold_r <= CNT_ZERO;
        end else begin
          cnt_r <= CNT_ZERO;
        end
      end else if (!bus.en) begin
        cnt_r    <= CNT_ZERO;
        locked_r <= 1'b0;
      end else if (publish_s) begin
        cnt_r       <= CNT_ONE;
        period_r    <= cnt_r;
        high_time_r <= hi_hold_r;
        prev_r      <= cnt_r;
        // The ARMED publish has no earlier full period to compare against
        locked_r    <= (state_r == RUN) && (cnt_r == prev_r);
        timeout_r   <= 1'b0;
      end else if (sat_s) begin
        cnt_r     <= CNT_ZERO;
        timeout_r <= 1'b1;
        locked_r  <= 1'b0;
      end else begin
        if (cnt_r != CNT_MAX) begin
          cnt_r <= cnt_r + CNT_ONE;
        end else begin
          cnt_r <= cnt_r;
        end
        if (fall_s) begin
          hi_hold_r <= cnt_r;
        end else begin
          hi_hold_r <= hi_hold_r;
        end
      end
    end
  end

  assign bus.period    = period_r;
  assign bus.high_time = high_time_r;
  assign bus.valid     = valid_r;
  assign bus.locked    = locked_r;
  assign bus.timeout   = timeout_r;
endmodule

// File: tb/tb_clock_ratio_meter.sv
// Directed bench for clock_ratio_meter (CNT_W=8) with hand-computed expectations.
module tb_clock_ratio_meter;
  localparam int CNT_W = 8;

  logic clk_in;
  logic nrst;
  int   nvec;
  int   nerr;
  int   cyc;
  int   nvalid;
  int   vper, vhi, vlock, vgap, last_vcyc;
  int   saved, first_to;

  clock_ratio_meter_if #(.CNT_W(CNT_W)) bus ();

  clock_ratio_meter #(.CNT_W(CNT_W)) dut (
    .clk_in (clk_in),
    .nrst   (nrst),
    .bus    (bus)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input int obs, input int exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clk_in cycle with sig_in driven to s; records any valid pulse.
  task automatic step(input logic s);
    bus.sig_in = s;
    @(posedge clk_in);
    #1;
    cyc++;
    if (bus.valid === 1'b1) begin
      nvalid++;
      vper      = int'(bus.period);
      vhi       = int'(bus.high_time);
      vlock     = int'(bus.locked);
      vgap      = cyc - last_vcyc;
      last_vcyc = cyc;
    end
  endtask

  task automatic wave(input int per, input int hi, input int n);
    for (int p = 0; p < n; p++) begin
      for (int c = 0; c < per; c++) begin
        step((c < hi) ? 1'b1 : 1'b0);
      end
    end
  endtask

  initial begin
    nvec = 0; nerr = 0; cyc = 0; nvalid = 0;
    vper = 0; vhi = 0; vlock = 0; vgap = 0; last_vcyc = 0;
    nrst = 1'b0;
    bus.en = 1'b0;
    bus.sig_in = 1'b0;
    #1;
    chk("reset_period", int'(bus.period), 0);
    chk("reset_high_time", int'(bus.high_time), 0);
    chk("reset_valid", int'(bus.valid), 0);
    chk("reset_locked", int'(bus.locked), 0);
    chk("reset_timeout", int'(bus.timeout), 0);
    @(posedge clk_in);
    @(posedge clk_in);
    #1;
    nrst = 1'b1;
    bus.en = 1'b1;
    step(1'b0);
    step(1'b0);

    // 50% duty, period 10
    wave(10, 5, 1);
    chk("p10_no_valid_after_arm", nvalid, 0);
    wave(10, 5, 1);
    chk("p10_first_count", nvalid, 1);
    chk("p10_first_period", vper, 10);
    chk("p10_first_high", vhi, 5);
    chk("p10_first_locked", vlock, 0);
    wave(10, 5, 1);
    chk("p10_second_count", nvalid, 2);
    chk("p10_second_locked", vlock, 1);
    chk("p10_gap", vgap, 10);

    // period 8 high 3 (first publish still measures the last 10 period)
    wave(8, 3, 3);
    chk("p8_period", vper, 8);
    chk("p8_high", vhi, 3);
    chk("p8_locked", vlock, 1);

    // minimum period 2
    wave(2, 1, 4);
    chk("p2_period", vper, 2);
    chk("p2_high", vhi, 1);
    chk("p2_locked", vlock, 1);
    chk("p2_gap", vgap, 2);

    // period change 10 -> 12
    wave(10, 5, 3);
    chk("relock10_locked", vlock, 1);
    wave(12, 6, 1);
    chk("chg_last10_period", vper, 10);
    wave(12, 6, 1);
    chk("chg_p12_period", vper, 12);
    chk("chg_p12_locked", vlock, 0);
    wave(12, 6, 1);
    chk("chg_p12_relocked", vlock, 1);

    // stuck low after lock at 10 -> timeout 248 cycles after the wave ends
    wave(10, 5, 3);
    chk("pre_to_period", vper, 10);
    chk("pre_to_locked", vlock, 1);
    saved = nvalid;
    first_to = 0;
    for (int i = 1; i <= 400; i++) begin
      step(1'b0);
      if (bus.timeout === 1'b1 && first_to == 0) first_to = i;
    end
    chk("to_latency", first_to, 248);
    chk("to_flag", int'(bus.timeout), 1);
    chk("to_locked", int'(bus.locked), 0);
    chk("to_period_hold", int'(bus.period), 10);
    chk("to_valid", int'(bus.valid), 0);
    chk("to_no_publish", nvalid, saved);

    // restart at period 20
    wave(20, 10, 1);
    chk("restart_arm_no_valid", nvalid, saved);
    chk("restart_timeout_held", int'(bus.timeout), 1);
    wave(20, 10, 1);
    chk("restart_period", vper, 20);
    chk("restart_high", vhi, 10);
    chk("restart_locked", vlock, 0);
    chk("restart_timeout_clr", int'(bus.timeout), 0);

    // en toggle while locked
    wave(20, 10, 1);
    chk("en_pre_locked", int'(bus.locked), 1);
    saved = nvalid;
    bus.en = 1'b0;
    step(1'b0);
    chk("en_low_locked", int'(bus.locked), 0);
    step(1'b0);
    step(1'b0);
    bus.en = 1'b1;
    chk("en_low_period_hold", int'(bus.period), 20);
    wave(20, 10, 1);
    chk("en_back_arm_no_valid", nvalid, saved);
    wave(20, 10, 1);
    chk("en_back_count", nvalid, saved + 1);
    chk("en_back_period", vper, 20);
    chk("en_back_locked", vlock, 0);

    // asynchronous reset mid-RUN
    wave(10, 5, 2);
    chk("rst_pre_period", vper, 10);
    step(1'b1);
    step(1'b1);
    #2;
    nrst = 1'b0;
    #1;
    chk("rst_async_period", int'(bus.period), 0);
    chk("rst_async_high", int'(bus.high_time), 0);
    chk("rst_async_locked", int'(bus.locked), 0);
    chk("rst_async_timeout", int'(bus.timeout), 0);
    bus.sig_in = 1'b0;
    @(posedge clk_in);
    @(posedge clk_in);
    #1;
    nrst = 1'b1;
    saved = nvalid;
    step(1'b0);
    wave(10, 5, 1);
    chk("rst_arm_no_valid", nvalid, saved);
    wave(10, 5, 1);
    chk("rst_first_count", nvalid, saved + 1);
    chk("rst_first_period", vper, 10);
    chk("rst_first_high", vhi, 5);
    chk("rst_first_locked", vlock, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
